// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing constants, timing struct and total helpers
package vga_timing_pkg;
    typedef struct packed {
        int h_active;
        int h_front;
        int h_sync;
        int h_back;
        int v_active;
        int v_front;
        int v_sync;
        int v_back;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_active: 480, v_front: 10, v_sync: 2,  v_back: 33
    };

    function automatic int h_total(vga_timing_t t);
        return t.h_active + t.h_front + t.h_sync + t.h_back;
    endfunction

    function automatic int v_total(vga_timing_t t);
        return t.v_active + t.v_front + t.v_sync + t.v_back;
    endfunction
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage enabled shift pipeline with synchronous reset value
// Ports: CLK clock, reset sync active-high (loads RST_VAL), en advance, d in, q out (q=d when DEPTH=0)
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // One dummy stage is kept at DEPTH=0 so the array is never empty; it is unobservable.
    localparam int N = DEPTH > 0 ? DEPTH : 1;

    logic [N-1:0][WIDTH-1:0] r;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r <= {N{RST_VAL}};
        end else if (en) begin
            r[0] <= d;
            for (int i = 1; i < N; i++) r[i] <= r[i-1];
        end
    end

    assign q = DEPTH == 0 ? d : r[N-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enabled VGA raster counters with delayed sync/blank and line/frame pulses
// Ports: CLK clock, reset sync active-high, pix_en pixel-rate enable;
//        x/y counters, active (undelayed visible), HSync/VSync/blank_n (DELAY beats behind x/y),
//        line_start/frame_start one-cycle pulses after a wrap of x / of x and y together
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640X480.h_active,
    parameter int H_FRONT  = VGA_640X480.h_front,
    parameter int H_SYNC   = VGA_640X480.h_sync,
    parameter int H_BACK   = VGA_640X480.h_back,
    parameter int V_ACTIVE = VGA_640X480.v_active,
    parameter int V_FRONT  = VGA_640X480.v_front,
    parameter int V_SYNC   = VGA_640X480.v_sync,
    parameter int V_BACK   = VGA_640X480.v_back,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CNT_W    = 11,
    parameter int DELAY    = 0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             HSync,
    output logic             VSync,
    output logic             blank_n,
    output logic             line_start,
    output logic             frame_start
);
    localparam vga_timing_t T = '{H_ACTIVE, H_FRONT, H_SYNC, H_BACK,
                                  V_ACTIVE, V_FRONT, V_SYNC, V_BACK};
    localparam int H_TOTAL = h_total(T);
    localparam int V_TOTAL = v_total(T);

    if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
        $error("vga_timing_gen: DELAY must be 0..15");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    // Region bounds carry one extra bit so a bound equal to 2^CNT_W does not wrap to 0.
    localparam logic [CNT_W:0] HA    = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] VA    = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] HS_LO = (CNT_W+1)'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W:0] HS_HI = (CNT_W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W:0] VS_LO = (CNT_W+1)'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W:0] VS_HI = (CNT_W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

    logic       x_wrap, y_wrap, hs, vs;
    logic [2:0] dly_q;

    always_comb begin
        x_wrap = x == H_LAST;
        y_wrap = y == V_LAST;
        hs     = {1'b0, x} >= HS_LO && {1'b0, x} < HS_HI;
        vs     = {1'b0, y} >= VS_LO && {1'b0, y} < VS_HI;
        active = {1'b0, x} < HA && {1'b0, y} < VA;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && x_wrap;
            frame_start <= pix_en && x_wrap && y_wrap;
            if (pix_en) begin
                x <= x_wrap ? '0 : x + 1'b1;
                if (x_wrap) y <= y_wrap ? '0 : y + 1'b1;
            end
        end
    end

    sync_delay_line #(
        .WIDTH  (3),
        .DEPTH  (DELAY),
        .RST_VAL({~H_POL, ~V_POL, 1'b0})
    ) u_dly (
        .CLK  (CLK),
        .reset(reset),
        .en   (pix_en),
        .d    ({hs ~^ H_POL, vs ~^ V_POL, active}),
        .q    (dly_q)
    );

    assign {HSync, VSync, blank_n} = dly_q;
endmodule
